// File: rtl/inst_fetch.sv
// Program-counter / fetch sequencer for the 9-bit 3BC core: drives the instruction ROM address,
// runs the Start/Done program handshake and counts retired fetches.
module inst_fetch #(
    parameter int              PC_W       = 10,
    parameter int              OFF_W      = 8,
    parameter logic [PC_W-1:0] START_ADDR = '0,
    parameter int              CNT_W      = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic             Stall,
    input  logic             BranchEn,
    input  logic             BranchAbs,
    input  logic [PC_W-1:0]  Target,
    input  logic [OFF_W-1:0] Offset,
    input  logic             HaltReq,
    output logic [PC_W-1:0]  InstAddress,
    output logic             FetchValid,
    output logic             Done,
    output logic [CNT_W-1:0] FetchCount
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        RUN    = 2'd2,
        HALTED = 2'd3
    } state_t;

    state_t            state, next_state;
    logic [PC_W-1:0]   pc, next_pc;
    logic [CNT_W-1:0]  fetch_cnt, next_cnt;
    logic              done_q, next_done;
    logic [PC_W-1:0]   offset_ext;
    logic              halt_accept;
    logic              advance;

    // Relative offsets are two's complement; the sum wraps modulo 2**PC_W.
    assign offset_ext  = {{(PC_W-OFF_W){Offset[OFF_W-1]}}, Offset};
    assign halt_accept = (state == RUN) && !Start && !Stall && HaltReq;
    assign advance     = (state == RUN) && !Start && !Stall && !HaltReq;

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values, independent of block ordering.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= IDLE;
            pc        <= START_ADDR;
            fetch_cnt <= '0;
            done_q    <= 1'b0;
        end else begin
            state     <= next_state;
            pc        <= next_pc;
            fetch_cnt <= next_cnt;
            done_q    <= next_done;
        end
    end

    // NOTE: each combinational block assigns a default first so no path leaves a
    // variable unassigned, which would otherwise infer a latch.
    always_comb begin
        next_state = state;
        if (Start) begin
            next_state = ARMED;
        end else begin
            case (state)
                IDLE:    next_state = IDLE;
                ARMED:   next_state = RUN;
                RUN:     if (!Stall && HaltReq) next_state = HALTED;
                HALTED:  next_state = HALTED;
                default: next_state = IDLE;
            endcase
        end
    end

    // Datapath: PC, fetch counter and registered Done.
    always_comb begin
        next_pc   = pc;
        next_cnt  = fetch_cnt;
        next_done = 1'b0;
        if (Start || state == IDLE || state == ARMED) begin
            next_pc  = START_ADDR;
            next_cnt = '0;
        end else if (advance) begin
            if (BranchEn && BranchAbs)
                next_pc = Target;
            else if (BranchEn)
                next_pc = pc + offset_ext;
            else
                next_pc = pc + PC_W'(1);
            if (fetch_cnt != {CNT_W{1'b1}})
                next_cnt = fetch_cnt + CNT_W'(1);
        end
        if (halt_accept || (state == HALTED && !Start))
            next_done = 1'b1;
    end

    always_comb begin
        InstAddress = pc;
        FetchValid  = (state == RUN) && !Stall;
        Done        = done_q;
        FetchCount  = fetch_cnt;
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: reset, sequencing, branches, wrap-around, stall, halt,
// restart and counter saturation, each with hand-computed expected values.
module tb_inst_fetch;

    localparam int PC_W  = 10;
    localparam int OFF_W = 8;
    localparam int CNT_W = 4;

    logic             Clk = 1'b0;
    logic             Reset, Start, Stall, BranchEn, BranchAbs, HaltReq;
    logic [PC_W-1:0]  Target;
    logic [OFF_W-1:0] Offset;
    logic [PC_W-1:0]  InstAddress;
    logic             FetchValid, Done;
    logic [CNT_W-1:0] FetchCount;

    int passed = 0;
    int total  = 0;

    inst_fetch #(.PC_W(PC_W), .OFF_W(OFF_W), .START_ADDR(10'd0), .CNT_W(CNT_W)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Stall(Stall),
        .BranchEn(BranchEn), .BranchAbs(BranchAbs), .Target(Target), .Offset(Offset),
        .HaltReq(HaltReq), .InstAddress(InstAddress), .FetchValid(FetchValid),
        .Done(Done), .FetchCount(FetchCount)
    );

    always #5 Clk = ~Clk;

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic clear_ctrl();
        Start = 0; Stall = 0; BranchEn = 0; BranchAbs = 0; HaltReq = 0;
        Target = '0; Offset = '0;
    endtask

    // Leaves the DUT in RUN with PC=0 and FetchCount=0.
    task automatic start_program();
        clear_ctrl();
        Start = 1; step();
        Start = 0; step();
    endtask

    task automatic advance(input int n);
        clear_ctrl();
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic jump(input logic [PC_W-1:0] addr);
        BranchEn = 1; BranchAbs = 1; Target = addr;
        step();
        clear_ctrl();
    endtask

    task automatic test_reset();
        clear_ctrl();
        Reset = 1; step(); step();
        Reset = 0;
        total++; if (InstAddress !== 10'd0) $display("FAIL reset_pc: got %0d want 0", InstAddress); else passed++;
        total++; if (FetchValid !== 1'b0) $display("FAIL reset_valid: got %b want 0", FetchValid); else passed++;
        total++; if (Done !== 1'b0) $display("FAIL reset_done: got %b want 0", Done); else passed++;
        total++; if (FetchCount !== 4'd0) $display("FAIL reset_cnt: got %0d want 0", FetchCount); else passed++;
        step();
        total++; if (InstAddress !== 10'd0 || FetchValid !== 1'b0) $display("FAIL idle_hold: pc=%0d valid=%b want 0/0", InstAddress, FetchValid); else passed++;
    endtask

    task automatic test_sequence();
        clear_ctrl();
        Start = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            total++; if (InstAddress !== 10'd0 || FetchValid !== 1'b0) $display("FAIL seq_armed%0d: pc=%0d valid=%b want 0/0", i, InstAddress, FetchValid); else passed++;
        end
        Start = 0;
        step();
        total++; if (InstAddress !== 10'd0 || FetchValid !== 1'b1) $display("FAIL seq_run0: pc=%0d valid=%b want 0/1", InstAddress, FetchValid); else passed++;
        for (int i = 1; i <= 5; i++) begin
            step();
            total++; if (InstAddress !== PC_W'(i)) $display("FAIL seq_pc%0d: got %0d want %0d", i, InstAddress, i); else passed++;
        end
        total++; if (FetchCount !== 4'd5) $display("FAIL seq_cnt: got %0d want 5", FetchCount); else passed++;
    endtask

    task automatic test_branch();
        start_program();
        advance(10);
        total++; if (InstAddress !== 10'd10) $display("FAIL br_setup: got %0d want 10", InstAddress); else passed++;
        BranchEn = 1; BranchAbs = 0; Offset = 8'hFC;
        step();
        total++; if (InstAddress !== 10'd6) $display("FAIL br_rel_neg: got %0d want 6", InstAddress); else passed++;
        BranchEn = 1; BranchAbs = 1; Target = 10'd700;
        step();
        total++; if (InstAddress !== 10'd700) $display("FAIL br_abs: got %0d want 700", InstAddress); else passed++;
        total++; if (FetchCount !== 4'd12) $display("FAIL br_cnt: got %0d want 12", FetchCount); else passed++;
        clear_ctrl();
    endtask

    task automatic test_wrap();
        jump(10'd1023);
        step();
        total++; if (InstAddress !== 10'd0) $display("FAIL wrap_inc: got %0d want 0", InstAddress); else passed++;
        jump(10'd3);
        BranchEn = 1; BranchAbs = 0; Offset = 8'hF8;
        step();
        total++; if (InstAddress !== 10'd1019) $display("FAIL wrap_rel_neg: got %0d want 1019", InstAddress); else passed++;
        jump(10'd1020);
        BranchEn = 1; BranchAbs = 0; Offset = 8'd10;
        step();
        total++; if (InstAddress !== 10'd6) $display("FAIL wrap_rel_pos: got %0d want 6", InstAddress); else passed++;
        clear_ctrl();
    endtask

    task automatic test_stall();
        logic [CNT_W-1:0] cnt0;
        jump(10'd20);
        cnt0 = FetchCount;
        Stall = 1; BranchEn = 1; BranchAbs = 1; Target = 10'd100;
        #1;
        total++; if (FetchValid !== 1'b0) $display("FAIL stall_valid: got %b want 0", FetchValid); else passed++;
        step();
        total++; if (InstAddress !== 10'd20) $display("FAIL stall_pc: got %0d want 20", InstAddress); else passed++;
        total++; if (FetchCount !== cnt0) $display("FAIL stall_cnt: got %0d want %0d", FetchCount, cnt0); else passed++;
        Stall = 0;
        #1;
        total++; if (FetchValid !== 1'b1) $display("FAIL unstall_valid: got %b want 1", FetchValid); else passed++;
        step();
        total++; if (InstAddress !== 10'd100) $display("FAIL unstall_branch: got %0d want 100", InstAddress); else passed++;
        clear_ctrl();
    endtask

    task automatic test_halt();
        logic [CNT_W-1:0] cnt0;
        jump(10'd40);
        cnt0 = FetchCount;
        HaltReq = 1; BranchEn = 1; BranchAbs = 1; Target = 10'd200;
        step();
        total++; if (InstAddress !== 10'd40) $display("FAIL halt_pc: got %0d want 40", InstAddress); else passed++;
        total++; if (Done !== 1'b1) $display("FAIL halt_done: got %b want 1", Done); else passed++;
        total++; if (FetchValid !== 1'b0) $display("FAIL halt_valid: got %b want 0", FetchValid); else passed++;
        clear_ctrl();
        step(); step();
        total++; if (InstAddress !== 10'd40 || Done !== 1'b1 || FetchCount !== cnt0)
            $display("FAIL halt_hold: pc=%0d done=%b cnt=%0d want 40/1/%0d", InstAddress, Done, FetchCount, cnt0);
        else passed++;
        Start = 1;
        step();
        total++; if (Done !== 1'b0 || InstAddress !== 10'd0 || FetchCount !== 4'd0)
            $display("FAIL halt_restart: done=%b pc=%0d cnt=%0d want 0/0/0", Done, InstAddress, FetchCount);
        else passed++;
        Start = 0;
        step();
        total++; if (FetchValid !== 1'b1 || InstAddress !== 10'd0) $display("FAIL halt_rerun: valid=%b pc=%0d want 1/0", FetchValid, InstAddress); else passed++;
    endtask

    task automatic test_abort();
        jump(10'd57);
        total++; if (InstAddress !== 10'd57) $display("FAIL abort_setup: got %0d want 57", InstAddress); else passed++;
        Start = 1;
        step();
        total++; if (InstAddress !== 10'd0 || FetchValid !== 1'b0 || FetchCount !== 4'd0)
            $display("FAIL abort_start: pc=%0d valid=%b cnt=%0d want 0/0/0", InstAddress, FetchValid, FetchCount);
        else passed++;
        Start = 0;
        step();
        advance(3);
        total++; if (InstAddress !== 10'd3) $display("FAIL abort_rerun: got %0d want 3", InstAddress); else passed++;
        Reset = 1;
        step();
        Reset = 0;
        total++; if (InstAddress !== 10'd0 || FetchValid !== 1'b0 || Done !== 1'b0 || FetchCount !== 4'd0)
            $display("FAIL midrun_reset: pc=%0d valid=%b done=%b cnt=%0d want 0/0/0/0", InstAddress, FetchValid, Done, FetchCount);
        else passed++;
    endtask

    task automatic test_saturate();
        start_program();
        advance(15);
        total++; if (FetchCount !== 4'd15) $display("FAIL sat_reach: got %0d want 15", FetchCount); else passed++;
        advance(5);
        total++; if (FetchCount !== 4'd15) $display("FAIL sat_hold: got %0d want 15", FetchCount); else passed++;
        total++; if (InstAddress !== 10'd20) $display("FAIL sat_pc: got %0d want 20", InstAddress); else passed++;
    endtask

    initial begin
        Reset = 1;
        clear_ctrl();
        test_reset();
        test_sequence();
        test_branch();
        test_wrap();
        test_stall();
        test_halt();
        test_abort();
        test_saturate();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
